gray_run_ctrl: RTL and testbench

Run controller for the 3-bit Gray-code counter. It accepts a start command with a step count, clears the counter, then drives the counter's enable for exactly that many advances, honouring hold and abort. It counts counter wrap-arounds and signals completion. It sits between the system-level control logic and the Gray counter, and replaces free-running enable stimulus.

---
 rtl/gray_run_ctrl_pkg.sv | 29 ++
 rtl/gray_step_checker.sv | 55 +++++
 rtl/gray_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_gray_run_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_run_ctrl_pkg.sv
// Shared types and constants for the Gray-counter run controller and its step checker.
package gray_run_ctrl_pkg;

   localparam int GRAY_W_DEF = 3;
   localparam int STEP_W_DEF = 8;
   localparam int WRAP_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } run_state_e;

   function automatic logic is_busy_state(input run_state_e s);
      return (s == CLEAR) || (s == RUN) || (s == PAUSE);
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Watches the Gray counter after each registered advance and flags any step that
// changes more than one bit, or a first step that did not start from zero.
module gray_step_checker
   import gray_run_ctrl_pkg::*;
#(
   parameter int GRAY_W = GRAY_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Sample,
   input  logic              Clear,
   input  logic [GRAY_W-1:0] GrayIn,
   output logic              Error
);

   logic [GRAY_W-1:0] prev_q, prev_d;
   logic              first_q, first_d;
   logic              error_q, error_d;
   logic              step_ok;

   // The first compare of a run also proves the counter really cleared.
   always_comb begin
      step_ok = (popcount(32'(GrayIn ^ prev_q)) == 1);
      if (first_q && (prev_q != '0)) begin
         step_ok = 1'b0;
      end
      prev_d  = GrayIn;
      first_d = first_q;
      error_d = error_q;
      if (Clear) begin
         first_d = 1'b1;
         error_d = 1'b0;
      end else if (Sample) begin
         first_d = 1'b0;
         if (!step_ok) begin
            error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         prev_q  <= '0;
         first_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         first_q <= first_d;
         error_q <= error_d;
      end
   end

   assign Error = error_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// Run controller for the Gray counter: clears it, enables it for exactly Steps advances
// (honouring Hold/Abort), counts wraps. Define GRAY_RUN_CTRL_CHECK_EN to add the step checker.
module gray_run_ctrl
   import gray_run_ctrl_pkg::*;
#(
   parameter int GRAY_W = GRAY_W_DEF,
   parameter int STEP_W = STEP_W_DEF,
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [STEP_W-1:0] Steps,
   input  logic              Hold,
   input  logic              Abort,
   input  logic [GRAY_W-1:0] GrayIn,
   input  logic              OverflowIn,
   output logic              CntClr,
   output logic              CntEn,
   output logic              Busy,
   output logic              Done,
   output logic [WRAP_W-1:0] WrapCount,
   output logic              Error
);

   run_state_e        state_q, state_d;
   logic [STEP_W-1:0] remaining_q, remaining_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              cnt_clr_q, cnt_clr_d;
   logic              cnt_en_q, cnt_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              en_dly_q, en_dly_d;
   logic              start_acc;

   // Next-state logic; Abort outranks every other transition out of a busy state.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      start_acc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               start_acc   = 1'b1;
               remaining_d = Steps;
               state_d     = CLEAR;
            end
         end
         CLEAR: begin
            if (Abort) begin
               state_d = IDLE;
            end else if (remaining_q == '0) begin
               state_d = DONE;
            end else if (Hold) begin
               state_d = PAUSE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            remaining_d = remaining_q - 1'b1;
            if (Abort) begin
               state_d = IDLE;
            end else if (remaining_q == STEP_W'(1)) begin
               state_d = DONE;
            end else if (Hold) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (Abort) begin
               state_d = IDLE;
            end else if (!Hold) begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Overflow is only trusted when the counter was actually enabled on the edge that raised it.
   always_comb begin
      wrap_d = wrap_q;
      if (start_acc) begin
         wrap_d = '0;
      end else if (OverflowIn && en_dly_q && (wrap_q != '1)) begin
         wrap_d = wrap_q + 1'b1;
      end
   end

   always_comb begin
      cnt_clr_d = (state_d == CLEAR);
      cnt_en_d  = (state_d == RUN);
      busy_d    = is_busy_state(state_d);
      done_d    = (state_d == DONE);
      en_dly_d  = cnt_en_q;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         wrap_q      <= '0;
         cnt_clr_q   <= 1'b0;
         cnt_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_dly_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wrap_q      <= wrap_d;
         cnt_clr_q   <= cnt_clr_d;
         cnt_en_q    <= cnt_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         en_dly_q    <= en_dly_d;
      end
   end

   assign CntClr    = cnt_clr_q;
   assign CntEn     = cnt_en_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign WrapCount = wrap_q;

`ifdef GRAY_RUN_CTRL_CHECK_EN
   gray_step_checker #(
      .GRAY_W (GRAY_W)
   ) u_checker (
      .Clk    (Clk),
      .Reset  (Reset),
      .Sample (en_dly_q),
      .Clear  (start_acc),
      .GrayIn (GrayIn),
      .Error  (Error)
   );
`else
   logic unused_gray;
   assign unused_gray = ^GrayIn;
   assign Error       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Directed bench for gray_run_ctrl driving a behavioural 3-bit Gray counter model.
module tb_gray_run_ctrl;

   logic       clk;
   logic       reset;
   logic       cnt_rst;
   logic       start;
   logic [7:0] steps_in;
   logic       hold;
   logic       abort;
   logic [2:0] gray_in;
   logic       ovf_in;
   logic       cnt_clr;
   logic       cnt_en;
   logic       busy;
   logic       done;
   logic [3:0] wrap_count;
   logic       error;

   logic [2:0] bin_q;
   logic       ovf_q;
   logic       fault_en;

   int total;
   int bad;

   typedef struct {
      int         steps;
      int         hold_at;
      int         hold_len;
      int         abort_at;
      int         restart_at;
      int         start_in_done;
      int         exp_en;
      int         exp_done;
      int         exp_wrap;
      logic [2:0] exp_gray;
   } vec_t;

   vec_t vecs [11];

   gray_run_ctrl dut (
      .Clk        (clk),
      .Reset      (reset),
      .Start      (start),
      .Steps      (steps_in),
      .Hold       (hold),
      .Abort      (abort),
      .GrayIn     (gray_in),
      .OverflowIn (ovf_in),
      .CntClr     (cnt_clr),
      .CntEn      (cnt_en),
      .Busy       (busy),
      .Done       (done),
      .WrapCount  (wrap_count),
      .Error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter model; fault_en makes it jump gray 001 -> 010
   always_ff @(posedge clk or posedge cnt_rst) begin
      if (cnt_rst) begin
         bin_q <= 3'd0;
         ovf_q <= 1'b0;
      end else if (cnt_clr) begin
         bin_q <= 3'd0;
         ovf_q <= 1'b0;
      end else if (cnt_en) begin
         if (fault_en && (bin_q == 3'd1)) bin_q <= 3'd3;
         else                             bin_q <= bin_q + 3'd1;
         ovf_q <= (bin_q == 3'd7);
      end else begin
         ovf_q <= 1'b0;
      end
   end

   assign gray_in = bin_q ^ (bin_q >> 1);
   assign ovf_in  = ovf_q;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int en_seen, clr_seen, done_seen, done_at, overlap, hold_left;
      bit hold_done, finished;
      en_seen = 0; clr_seen = 0; done_seen = 0; done_at = -1; overlap = 0;
      hold_left = 0; hold_done = 0; finished = 0;
      @(negedge clk);
      start    = 1'b1;
      steps_in = 8'(v.steps);
      @(negedge clk);
      for (int k = 0; k < 700; k++) begin
         if (k > 0) @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (!busy && !done) begin
            finished = 1;
            break;
         end
         if (cnt_en) en_seen++;
         if (cnt_clr) clr_seen++;
         if (cnt_en && cnt_clr) overlap++;
         if (done) begin
            done_seen++;
            done_at = k;
            if (v.start_in_done != 0) begin
               start    = 1'b1;
               steps_in = 8'd5;
            end
         end
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) hold = 1'b0;
         end else if (!hold_done && v.hold_len > 0 && en_seen == v.hold_at && busy) begin
            hold      = 1'b1;
            hold_left = v.hold_len;
            hold_done = 1;
         end
         if (v.abort_at >= 0 && en_seen == v.abort_at && cnt_en) abort = 1'b1;
         if (v.restart_at >= 0 && en_seen == v.restart_at && cnt_en) begin
            start    = 1'b1;
            steps_in = 8'd3;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      hold  = 1'b0;
      if (!finished) checkOutput($sformatf("v%0d_timeout", idx), 1, 0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d_en_cycles", idx), en_seen, v.exp_en);
      checkOutput($sformatf("v%0d_clr_cycles", idx), clr_seen, 1);
      checkOutput($sformatf("v%0d_en_clr_overlap", idx), overlap, 0);
      checkOutput($sformatf("v%0d_done_pulses", idx), done_seen, v.exp_done);
      if (v.exp_done != 0)
         checkOutput($sformatf("v%0d_done_cycle", idx), done_at, 1 + v.steps + v.hold_len);
      checkOutput($sformatf("v%0d_wrap", idx), int'(wrap_count), v.exp_wrap);
      checkOutput($sformatf("v%0d_gray", idx), int'(gray_in), int'(v.exp_gray));
      checkOutput($sformatf("v%0d_error", idx), int'(error), 0);
      checkOutput($sformatf("v%0d_idle_after", idx), int'(busy), 0);
   endtask

   initial begin
      total = 0; bad = 0;
      start = 1'b0; steps_in = 8'd0; hold = 1'b0; abort = 1'b0; fault_en = 1'b0;
      reset = 1'b1; cnt_rst = 1'b1;

      //          steps hold_at len abort rest sid en  done wrap gray
      vecs[0]  = '{10,  -1,    0,  -1,   -1,  0,  10,  1,   1,   3'b011};
      vecs[1]  = '{20,   7,    3,  -1,   -1,  0,  20,  1,   2,   3'b110};
      vecs[2]  = '{0,   -1,    0,  -1,   -1,  0,  0,   1,   0,   3'b000};
      vecs[3]  = '{200, -1,    0,  -1,   -1,  0,  200, 1,   15,  3'b000};
      vecs[4]  = '{50,  -1,    0,   5,   -1,  0,  5,   0,   0,   3'b111};
      vecs[5]  = '{8,   -1,    0,  -1,   -1,  0,  8,   1,   1,   3'b000};
      vecs[6]  = '{1,   -1,    0,  -1,   -1,  0,  1,   1,   0,   3'b001};
      vecs[7]  = '{255, 100,   2,  -1,   -1,  0,  255, 1,   15,  3'b100};
      vecs[8]  = '{3,    0,    2,  -1,   -1,  0,  3,   1,   0,   3'b010};
      vecs[9]  = '{12,  -1,    0,  -1,    4,  0,  12,  1,   1,   3'b110};
      vecs[10] = '{4,   -1,    0,  -1,   -1,  1,  4,   1,   0,   3'b110};

      @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_en", int'(cnt_en), 0);
      #62;
      reset = 1'b0; cnt_rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_clr", int'(cnt_clr), 0);
      checkOutput("post_reset_en", int'(cnt_en), 0);
      checkOutput("post_reset_busy", int'(busy), 0);
      checkOutput("post_reset_done", int'(done), 0);
      checkOutput("post_reset_wrap", int'(wrap_count), 0);
      checkOutput("post_reset_error", int'(error), 0);

      for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

      // Reset mid-run: everything drops at once, no Done afterwards
      @(negedge clk);
      start = 1'b1; steps_in = 8'd30;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("midrun_busy", int'(busy), 1);
      checkOutput("midrun_wrap", int'(wrap_count), 2);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_en", int'(cnt_en), 0);
      checkOutput("async_reset_busy", int'(busy), 0);
      checkOutput("async_reset_wrap", int'(wrap_count), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("after_reset_done_%0d", k), int'(done), 0);
         checkOutput($sformatf("after_reset_busy_%0d", k), int'(busy), 0);
      end

`ifdef GRAY_RUN_CTRL_CHECK_EN
      fault_en = 1'b1;
      @(negedge clk);
      start = 1'b1; steps_in = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("err_before_bad_step", int'(error), 0);
      @(negedge clk);
      checkOutput("err_after_bad_step", int'(error), 1);
      repeat (6) @(negedge clk);
      checkOutput("err_sticky", int'(error), 1);
      checkOutput("err_run_idle", int'(busy), 0);
      fault_en = 1'b0;
      start = 1'b1; steps_in = 8'd2;
      @(negedge clk);
      start = 1'b0;
      checkOutput("err_cleared_by_start", int'(error), 0);
      repeat (5) @(negedge clk);
      checkOutput("err_clean_run", int'(error), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
